sys_unit_sched: RTL and testbench

- Controller and arbiter that shares the single system functional unit (sys_unit) among NUM_REQ issue ports.
- Picks one system op at a time by round-robin, holds it until its ROB tag reaches the ROB head, then fires the unit for one cycle.
- Waits SYS_LATENCY cycles, then presents the result to writeback over a valid/ready handshake.
- Sits between the issue queues and sys_unit / the writeback bus. The whole path is serialized: at most one system op is in flight.

---
 rtl/sys_unit_sched_pkg.sv | 30 +++
 rtl/sys_unit_sched_rr_arbiter.sv | 43 ++++
 rtl/sys_unit_sched.sv | 164 ++++++++++++++++
 tb/tb_sys_unit_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_unit_sched_pkg.sv
// Shared types for the system-unit scheduler.
//   DATA_WIDTH        : operand / result width on the sys_unit path
//   ROB_TAG_WIDTH     : default ROB tag width
//   decoded_alu_op_t  : decoded op handed to sys_unit
//   sys_sched_state_t : scheduler FSM states
package sys_unit_sched_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ROB_TAG_WIDTH = 6;
  localparam int ALU_OP_WIDTH  = 4;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_NOP    = 4'd0,
    ALU_CSRRW  = 4'd1,
    ALU_CSRRS  = 4'd2,
    ALU_CSRRC  = 4'd3,
    ALU_ECALL  = 4'd4,
    ALU_EBREAK = 4'd5,
    ALU_FENCE  = 4'd6,
    ALU_MRET   = 4'd7
  } decoded_alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HEAD = 2'd1,
    ST_EXEC      = 2'd2,
    ST_WB        = 2'd3
  } sys_sched_state_t;

endpackage

// File: rtl/sys_unit_sched_rr_arbiter.sv
// Round-robin arbiter shared by the single-instance functional-unit schedulers.
// Grants the first asserted request at or above ptr, wrapping to index 0.
//   valid     : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot grant (zero when no request)
//   grant_idx : binary index of the grant
//   any       : at least one request is granted
module rr_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic [PTR_WIDTH-1:0] grant_idx,
  output logic                 any
);

  // Two ordered passes avoid a modulo: first the upper segment [ptr, NUM_REQ),
  // then the wrapped lower segment [0, ptr).
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no
    // path leaves a value unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && valid[i] && (PTR_WIDTH'(i) >= ptr)) begin
        any       = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PTR_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && valid[i] && (PTR_WIDTH'(i) < ptr)) begin
        any       = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PTR_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/sys_unit_sched.sv
// Serializing scheduler for the single system functional unit.
// Arbitrates NUM_REQ issue ports round-robin, holds the chosen op until its ROB
// tag is at the ROB head, fires sys_unit for one cycle, waits SYS_LATENCY
// cycles, then offers the result to writeback with a valid/ready handshake.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_req_* / o_req_ready : per-port issue requests and one-hot accept
//   i_rob_head_tag        : tag of the oldest uncommitted instruction
//   i_flush               : abandon whatever is in flight
//   o_sys_*               : enable and operands to sys_unit
//   i_sys_dest            : sys_unit result
//   o_wb_*, i_wb_ready    : writeback handshake
module sys_unit_sched
  import sys_unit_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TAG_WIDTH   = ROB_TAG_WIDTH,
  parameter int SYS_LATENCY = 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [NUM_REQ-1:0]                     i_req_valid,
  output logic [NUM_REQ-1:0]                     o_req_ready,
  input  logic [NUM_REQ-1:0][ALU_OP_WIDTH-1:0]   i_req_op,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     i_req_src1,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     i_req_src2,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]      i_req_tag,
  input  logic [TAG_WIDTH-1:0]                   i_rob_head_tag,
  input  logic                                   i_flush,
  output logic                                   o_sys_enabled,
  output decoded_alu_op_t                        o_sys_op,
  output logic [DATA_WIDTH-1:0]                  o_sys_src1,
  output logic [DATA_WIDTH-1:0]                  o_sys_src2,
  input  logic [DATA_WIDTH-1:0]                  i_sys_dest,
  output logic                                   o_wb_valid,
  input  logic                                   i_wb_ready,
  output logic [DATA_WIDTH-1:0]                  o_wb_data,
  output logic [TAG_WIDTH-1:0]                   o_wb_tag
);

  localparam int PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_WIDTH = (SYS_LATENCY > 0) ? $clog2(SYS_LATENCY + 1) : 1;

  sys_sched_state_t       state_q, state_d;
  logic [PTR_WIDTH-1:0]   rr_ptr_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  decoded_alu_op_t        op_q;
  logic [DATA_WIDTH-1:0]  src1_q, src2_q, result_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   sys_enabled_q;

  logic [NUM_REQ-1:0]     grant;
  logic [PTR_WIDTH-1:0]   grant_idx;
  logic                   grant_any;
  logic                   accept, fire, capture_result;

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_arb (
    .valid     (i_req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Next state and per-cycle strobes. Flush is applied last so it overrides
  // a request handshake, a head match and counter expiry in the same cycle.
  always_comb begin
    state_d        = state_q;
    o_req_ready    = '0;
    accept         = 1'b0;
    fire           = 1'b0;
    capture_result = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        o_req_ready = grant;
        if (grant_any) begin
          accept  = 1'b1;
          state_d = ST_WAIT_HEAD;
        end
      end
      ST_WAIT_HEAD: begin
        if (tag_q == i_rob_head_tag) begin
          fire    = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Counter reaches zero in the last EXEC cycle, which is when the
        // registered sys_unit output for this op is on i_sys_dest.
        if (cnt_q == '0) begin
          capture_result = 1'b1;
          state_d        = ST_WB;
        end
      end
      ST_WB: begin
        if (i_wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) begin
      state_d        = ST_IDLE;
      o_req_ready    = '0;
      accept         = 1'b0;
      fire           = 1'b0;
      capture_result = 1'b0;
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q      <= '0;
      cnt_q         <= '0;
      op_q          <= ALU_NOP;
      src1_q        <= '0;
      src2_q        <= '0;
      tag_q         <= '0;
      result_q      <= '0;
      sys_enabled_q <= 1'b0;
    end else begin
      sys_enabled_q <= fire;

      if (accept) begin
        op_q     <= decoded_alu_op_t'(i_req_op[grant_idx]);
        src1_q   <= i_req_src1[grant_idx];
        src2_q   <= i_req_src2[grant_idx];
        tag_q    <= i_req_tag[grant_idx];
        rr_ptr_q <= (grant_idx == PTR_WIDTH'(NUM_REQ - 1)) ? '0
                                                           : grant_idx + PTR_WIDTH'(1);
      end else if (i_flush) begin
        op_q   <= ALU_NOP;
        src1_q <= '0;
        src2_q <= '0;
        tag_q  <= '0;
      end

      if (fire) begin
        cnt_q <= CNT_WIDTH'(SYS_LATENCY);
      end else if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_WIDTH'(1);
      end

      if (capture_result) result_q <= i_sys_dest;
    end
  end

  assign o_sys_enabled = sys_enabled_q;
  assign o_sys_op      = op_q;
  assign o_sys_src1    = src1_q;
  assign o_sys_src2    = src2_q;
  // Gated by flush so a writeback handshake coincident with flush never counts.
  assign o_wb_valid    = (state_q == ST_WB) && !i_flush;
  assign o_wb_data     = result_q;
  assign o_wb_tag      = tag_q;

endmodule

// File: tb/tb_sys_unit_sched.sv
// Self-checking bench for sys_unit_sched: a table of full transactions on a
// SYS_LATENCY=1 instance, plus hand-written sequences for alternation,
// SYS_LATENCY=3 timing and asynchronous reset.
module tb_sys_unit_sched;
  import sys_unit_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int TW   = ROB_TAG_WIDTH;

  logic                                i_clk;
  logic                                i_rst_n;
  logic [NREQ-1:0]                     i_req_valid, i_req_valid2;
  logic [NREQ-1:0]                     o_req_ready, o_req_ready2;
  logic [NREQ-1:0][ALU_OP_WIDTH-1:0]   i_req_op;
  logic [NREQ-1:0][DATA_WIDTH-1:0]     i_req_src1, i_req_src2;
  logic [NREQ-1:0][TW-1:0]             i_req_tag;
  logic [TW-1:0]                       i_rob_head_tag;
  logic                                i_flush;
  logic                                o_sys_enabled, o_sys_enabled2;
  decoded_alu_op_t                     o_sys_op, o_sys_op2;
  logic [DATA_WIDTH-1:0]               o_sys_src1, o_sys_src2, o_sys_src1_2, o_sys_src2_2;
  logic [DATA_WIDTH-1:0]               i_sys_dest;
  logic                                o_wb_valid, o_wb_valid2;
  logic                                i_wb_ready, i_wb_ready2;
  logic [DATA_WIDTH-1:0]               o_wb_data, o_wb_data2;
  logic [TW-1:0]                       o_wb_tag, o_wb_tag2;

  sys_unit_sched #(.NUM_REQ(NREQ), .TAG_WIDTH(TW), .SYS_LATENCY(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_src1(i_req_src1), .i_req_src2(i_req_src2),
    .i_req_tag(i_req_tag), .i_rob_head_tag(i_rob_head_tag), .i_flush(i_flush),
    .o_sys_enabled(o_sys_enabled), .o_sys_op(o_sys_op),
    .o_sys_src1(o_sys_src1), .o_sys_src2(o_sys_src2), .i_sys_dest(i_sys_dest),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
    .o_wb_data(o_wb_data), .o_wb_tag(o_wb_tag)
  );

  sys_unit_sched #(.NUM_REQ(NREQ), .TAG_WIDTH(TW), .SYS_LATENCY(3)) dut3 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid2), .o_req_ready(o_req_ready2),
    .i_req_op(i_req_op), .i_req_src1(i_req_src1), .i_req_src2(i_req_src2),
    .i_req_tag(i_req_tag), .i_rob_head_tag(i_rob_head_tag), .i_flush(i_flush),
    .o_sys_enabled(o_sys_enabled2), .o_sys_op(o_sys_op2),
    .o_sys_src1(o_sys_src1_2), .o_sys_src2(o_sys_src2_2), .i_sys_dest(i_sys_dest),
    .o_wb_valid(o_wb_valid2), .i_wb_ready(i_wb_ready2),
    .o_wb_data(o_wb_data2), .o_wb_tag(o_wb_tag2)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000ns, required finish earlier");
    $fatal(1, "watchdog expired");
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // flush_at: 0 none, 1 in first WAIT_HEAD cycle, 2 in enable cycle, 3 in WB.
  typedef struct {
    logic [NREQ-1:0]       mask;
    int                    grant;
    logic [TW-1:0]         tag;
    decoded_alu_op_t       op;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [DATA_WIDTH-1:0] dest;
    int                    head_delay;
    int                    wb_delay;
    int                    flush_at;
  } vec_t;

  vec_t vecs [8];

  task automatic drive_ports(input vec_t v);
    for (int p = 0; p < NREQ; p++) begin
      i_req_op[p]   = v.op;
      i_req_src1[p] = v.src1 + DATA_WIDTH'(p);
      i_req_src2[p] = v.src2 ^ DATA_WIDTH'(p);
      i_req_tag[p]  = v.tag;
    end
  endtask

  // Full transaction on the SYS_LATENCY=1 instance; starts and ends at
  // posedge+1 with the scheduler idle.
  task automatic run_op(input int n, input vec_t v);
    logic [NREQ-1:0] exp_ready;
    string           id;
    id        = $sformatf("v%0d", n);
    exp_ready = NREQ'(1) << v.grant;
    drive_ports(v);
    i_sys_dest     = v.dest;
    i_wb_ready     = 1'b0;
    i_rob_head_tag = (v.head_delay == 0) ? v.tag : ~v.tag;
    i_req_valid    = v.mask;
    #1;
    check({id, " req_ready"}, 64'(o_req_ready), 64'(exp_ready));
    tick();                                   // accept edge
    i_req_valid = '0;
    #1;
    check({id, " ready_busy"}, 64'(o_req_ready), 64'd0);
    check({id, " sys_op"},     64'(o_sys_op),   64'(v.op));
    check({id, " sys_src1"},   64'(o_sys_src1), 64'(v.src1 + DATA_WIDTH'(v.grant)));
    check({id, " sys_src2"},   64'(o_sys_src2), 64'(v.src2 ^ DATA_WIDTH'(v.grant)));

    if (v.flush_at == 1) begin
      i_rob_head_tag = v.tag;                 // flush must beat the head match
      i_flush        = 1'b1;
      #1;
      check({id, " flw_wbv"}, 64'(o_wb_valid), 64'd0);
      check({id, " flw_rdy"}, 64'(o_req_ready), 64'd0);
      tick();
      i_flush = 1'b0;
      #1;
      check({id, " flw_en"},   64'(o_sys_enabled), 64'd0);
      check({id, " flw_src"},  64'(o_sys_src1),    64'd0);
      check({id, " flw_wbv2"}, 64'(o_wb_valid),    64'd0);
      return;
    end

    for (int i = 0; i < v.head_delay; i++) begin
      check($sformatf("%s wait_en%0d", id, i), 64'(o_sys_enabled), 64'd0);
      tick();
    end
    i_rob_head_tag = v.tag;
    #1;
    check({id, " en_match"}, 64'(o_sys_enabled), 64'd0);
    tick();
    check({id, " en_pulse"}, 64'(o_sys_enabled), 64'd1);
    check({id, " en_src1"},  64'(o_sys_src1), 64'(v.src1 + DATA_WIDTH'(v.grant)));

    if (v.flush_at == 2) begin
      i_flush = 1'b1;
      #1;
      check({id, " fle_wbv"}, 64'(o_wb_valid), 64'd0);
      tick();
      i_flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("%s fle_en%0d", id, i),  64'(o_sys_enabled), 64'd0);
        check($sformatf("%s fle_wbv%0d", id, i), 64'(o_wb_valid),    64'd0);
        tick();
      end
      return;
    end

    tick();
    check({id, " en_drop"},  64'(o_sys_enabled), 64'd0);
    check({id, " wbv_early"}, 64'(o_wb_valid),   64'd0);
    tick();
    check({id, " wbv"},  64'(o_wb_valid), 64'd1);
    check({id, " wbd"},  64'(o_wb_data),  64'(v.dest));
    check({id, " wbt"},  64'(o_wb_tag),   64'(v.tag));

    if (v.flush_at == 3) begin
      i_wb_ready = 1'b1;
      i_flush    = 1'b1;
      #1;
      check({id, " flb_wbv"}, 64'(o_wb_valid), 64'd0);
      tick();
      i_flush    = 1'b0;
      i_wb_ready = 1'b0;
      #1;
      check({id, " flb_wbv2"}, 64'(o_wb_valid), 64'd0);
      return;
    end

    for (int i = 0; i < v.wb_delay; i++) begin
      tick();
      check($sformatf("%s hold_v%0d", id, i), 64'(o_wb_valid), 64'd1);
      check($sformatf("%s hold_d%0d", id, i), 64'(o_wb_data),  64'(v.dest));
    end
    i_wb_ready  = 1'b1;
    i_req_valid = v.mask;                     // no accept in the handshake cycle
    #1;
    check({id, " wb_no_rdy"}, 64'(o_req_ready), 64'd0);
    i_req_valid = '0;
    tick();
    i_wb_ready = 1'b0;
    #1;
    check({id, " wbv_done"}, 64'(o_wb_valid), 64'd0);
  endtask

  initial begin
    int acc_port [4];
    int acc_cyc  [4];
    int nacc;
    vec_t post;

    vecs[0] = '{2'b01, 0, 6'd5,  ALU_CSRRW,  32'h0000_0100, 32'h0000_0200, 32'hDEAD_0005, 0,  3, 0};
    vecs[1] = '{2'b11, 1, 6'd9,  ALU_CSRRS,  32'h1111_0000, 32'h0000_2222, 32'h0000_9999, 10, 0, 0};
    vecs[2] = '{2'b11, 0, 6'd17, ALU_ECALL,  32'h2000_0000, 32'h0000_0017, 32'h0000_1717, 0,  0, 1};
    vecs[3] = '{2'b11, 1, 6'd18, ALU_EBREAK, 32'h3000_0000, 32'h0000_0018, 32'h0000_1818, 0,  0, 2};
    vecs[4] = '{2'b10, 1, 6'd19, ALU_FENCE,  32'h4000_0000, 32'h0000_0019, 32'h0000_1919, 0,  0, 3};
    vecs[5] = '{2'b10, 1, 6'd0,  ALU_CSRRC,  32'h5000_0000, 32'h0000_0020, 32'hA5A5_0000, 2,  1, 0};
    vecs[6] = '{2'b01, 0, 6'd40, ALU_MRET,   32'h6000_0000, 32'h0000_0040, 32'h5A5A_4040, 0,  0, 0};
    vecs[7] = '{2'b11, 1, 6'd63, ALU_CSRRW,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  2, 0};

    i_rst_n        = 1'b0;
    i_req_valid    = '0;
    i_req_valid2   = '0;
    i_req_op       = '0;
    i_req_src1     = '0;
    i_req_src2     = '0;
    i_req_tag      = '0;
    i_rob_head_tag = '0;
    i_flush        = 1'b0;
    i_sys_dest     = '0;
    i_wb_ready     = 1'b0;
    i_wb_ready2    = 1'b0;

    #3;
    check("rst en",    64'(o_sys_enabled), 64'd0);
    check("rst wbv",   64'(o_wb_valid),    64'd0);
    check("rst rdy",   64'(o_req_ready),   64'd0);
    check("rst wbd",   64'(o_wb_data),     64'd0);
    check("rst wbt",   64'(o_wb_tag),      64'd0);
    check("rst src1",  64'(o_sys_src1),    64'd0);
    check("rst op",    64'(o_sys_op),      64'(ALU_NOP));
    tick();
    tick();
    #3;
    i_rst_n = 1'b1;
    tick();

    for (int n = 0; n < 8; n++) run_op(n, vecs[n]);

    // Both ports requesting continuously: grants alternate, one op per 5 cycles.
    for (int p = 0; p < NREQ; p++) begin
      i_req_op[p]   = ALU_CSRRS;
      i_req_src1[p] = 32'h0000_7000 + DATA_WIDTH'(p);
      i_req_src2[p] = 32'h0;
      i_req_tag[p]  = 6'd12;
    end
    i_rob_head_tag = 6'd12;
    i_sys_dest     = 32'h0000_ABCD;
    i_wb_ready     = 1'b1;
    i_req_valid    = 2'b11;
    nacc           = 0;
    for (int c = 0; c < 40 && nacc < 4; c++) begin
      #1;
      if (o_req_ready != '0) begin
        check($sformatf("alt onehot%0d", nacc), 64'($countones(o_req_ready)), 64'd1);
        acc_port[nacc] = o_req_ready[1] ? 1 : 0;
        acc_cyc[nacc]  = c;
        nacc++;
      end
      tick();
    end
    i_req_valid = '0;
    check("alt accepts", 64'(nacc), 64'd4);
    for (int k = 0; k < nacc; k++) begin
      check($sformatf("alt port%0d", k), 64'(acc_port[k]), 64'(k % 2));
      if (k > 0) check($sformatf("alt gap%0d", k), 64'(acc_cyc[k] - acc_cyc[k-1]), 64'd5);
    end
    for (int i = 0; i < 6; i++) tick();
    i_wb_ready = 1'b0;
    #1;
    check("alt drained", 64'(o_wb_valid), 64'd0);

    // SYS_LATENCY=3: result is the value on i_sys_dest in the last EXEC cycle.
    for (int p = 0; p < NREQ; p++) i_req_tag[p] = 6'd20;
    i_rob_head_tag = 6'd20;
    i_req_valid2   = 2'b01;
    #1;
    check("l3 rdy", 64'(o_req_ready2), 64'd1);
    tick();
    i_req_valid2 = '0;
    tick();
    check("l3 en", 64'(o_sys_enabled2), 64'd1);
    i_sys_dest = 32'hA000_0000;
    for (int k = 1; k <= 4; k++) begin
      tick();
      i_sys_dest = 32'hA000_0000 + DATA_WIDTH'(k);
      #1;
      if (k < 4) begin
        check($sformatf("l3 wbv_early%0d", k), 64'(o_wb_valid2), 64'd0);
      end else begin
        check("l3 wbv",  64'(o_wb_valid2), 64'd1);
        check("l3 wbd",  64'(o_wb_data2),  64'hA000_0003);
        check("l3 wbt",  64'(o_wb_tag2),   64'd20);
      end
    end
    i_wb_ready2 = 1'b1;
    tick();
    i_wb_ready2 = 1'b0;
    #1;
    check("l3 done", 64'(o_wb_valid2), 64'd0);

    // Asynchronous reset in the enable cycle of an op on port 0 (rr_ptr -> 1).
    for (int p = 0; p < NREQ; p++) begin
      i_req_tag[p]  = 6'd33;
      i_req_src1[p] = 32'h0000_3300 + DATA_WIDTH'(p);
    end
    i_rob_head_tag = 6'd33;
    i_sys_dest     = 32'h3333_3333;
    i_req_valid    = 2'b01;
    #1;
    check("rmid rdy", 64'(o_req_ready), 64'd1);
    tick();
    i_req_valid = '0;
    tick();
    check("rmid en", 64'(o_sys_enabled), 64'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rmid en0",   64'(o_sys_enabled), 64'd0);
    check("rmid wbv0",  64'(o_wb_valid),    64'd0);
    check("rmid src0",  64'(o_sys_src1),    64'd0);
    check("rmid wbt0",  64'(o_wb_tag),      64'd0);
    check("rmid wbd0",  64'(o_wb_data),     64'd0);
    tick();
    #3;
    i_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      check($sformatf("rpost wbv%0d", i), 64'(o_wb_valid), 64'd0);
      tick();
    end

    // rr_ptr returned to 0 by reset, so port 0 wins with both ports valid.
    post = '{2'b11, 0, 6'd44, ALU_CSRRC, 32'h0000_4400, 32'h0000_0044, 32'hCAFE_0044, 0, 0, 0};
    run_op(8, post);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
